// File: rtl/alu_serial_seq.sv
`default_nettype none
// ============================================================================
// Module   : alu_serial_seq
// Brief    : Bit-serial ALU sequencer, one bit per cycle LSB first, single
//            carry flop, start/busy/done handshake.
// Revision : 1.0
// ============================================================================
module alu_serial_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start,
    input  logic [WIDTH-1:0] src1,
    input  logic [WIDTH-1:0] src2,
    input  logic             A_invert,
    input  logic             B_invert,
    input  logic [1:0]       operation,
    input  logic [2:0]       comp_sel,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             cout,
    output logic             overflow
);

    localparam int               c_CW      = $clog2(WIDTH);
    localparam logic [c_CW-1:0]  c_LAST    = c_CW'(WIDTH - 1);

    localparam logic [1:0]       c_IDLE    = 2'd0;
    localparam logic [1:0]       c_RUN     = 2'd1;
    localparam logic [1:0]       c_DONE    = 2'd2;

    localparam logic [1:0]       c_OP_AND  = 2'b00;
    localparam logic [1:0]       c_OP_OR   = 2'b01;
    localparam logic [1:0]       c_OP_LESS = 2'b11;

    logic [1:0]       r_state;
    logic [c_CW-1:0]  r_cnt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_ainv;
    logic             r_binv;
    logic [1:0]       r_op;
    logic [2:0]       r_csel;
    logic             r_carry;
    logic             r_zacc;

    logic             w_a;
    logic             w_b;
    logic             w_g;
    logic             w_p;
    logic             w_sum;
    logic             w_carry_nx;
    logic             w_bit;
    logic             w_ovf_raw;
    logic             w_less;
    logic             w_equal;
    logic             w_cmp;
    logic [WIDTH-1:0] w_res_final;

    assign w_a        = r_a[0] ^ r_ainv;
    assign w_b        = r_b[0] ^ r_binv;
    assign w_g        = w_a & w_b;
    assign w_p        = w_a | w_b;
    assign w_sum      = w_a ^ w_b ^ r_carry;
    assign w_carry_nx = w_g | (w_p & r_carry);

    // Only meaningful on the MSB cycle, where r_carry is the carry into bit WIDTH-1.
    assign w_ovf_raw  = r_carry ^ w_carry_nx;
    assign w_less     = w_sum ^ w_ovf_raw;
    assign w_equal    = r_zacc & ~w_sum;

    assign busy       = (r_state == c_RUN) || (r_state == c_DONE);
    assign done       = (r_state == c_DONE);

    always_comb begin
        w_bit = w_sum;
        case (r_op)
            c_OP_AND: w_bit = w_g;
            c_OP_OR:  w_bit = w_p;
            default:  w_bit = w_sum;
        endcase
    end

    always_comb begin
        w_cmp = 1'b0;
        case (r_csel)
            3'b000:  w_cmp = w_less;
            3'b001:  w_cmp = ~w_less & ~w_equal;
            3'b010:  w_cmp = w_less | w_equal;
            3'b011:  w_cmp = ~w_less;
            3'b110:  w_cmp = w_equal;
            3'b100:  w_cmp = ~w_equal;
            default: w_cmp = 1'b0;
        endcase
    end

    // Result bits are shifted into the top of the A register as A drains out.
    always_comb begin
        w_res_final = {w_bit, r_a[WIDTH-1:1]};
        if (r_op == c_OP_LESS) begin
            w_res_final = {{(WIDTH-1){1'b0}}, w_cmp};
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state  <= c_IDLE;
            r_cnt    <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_ainv   <= 1'b0;
            r_binv   <= 1'b0;
            r_op     <= 2'b00;
            r_csel   <= 3'b000;
            r_carry  <= 1'b0;
            r_zacc   <= 1'b0;
            result   <= '0;
            zero     <= 1'b0;
            cout     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        r_a     <= src1;
                        r_b     <= src2;
                        r_ainv  <= A_invert;
                        r_binv  <= B_invert;
                        r_op    <= operation;
                        r_csel  <= comp_sel;
                        r_carry <= B_invert;
                        r_zacc  <= 1'b1;
                        r_cnt   <= '0;
                        r_state <= c_RUN;
                    end
                end
                c_RUN: begin
                    r_a     <= {w_bit, r_a[WIDTH-1:1]};
                    r_b     <= {1'b0, r_b[WIDTH-1:1]};
                    r_carry <= w_carry_nx;
                    r_zacc  <= w_equal;
                    if (r_cnt == c_LAST) begin
                        r_state  <= c_DONE;
                        result   <= w_res_final;
                        zero     <= ~|w_res_final;
                        cout     <= w_carry_nx;
                        overflow <= r_op[1] & w_ovf_raw;
                    end else begin
                        r_cnt <= r_cnt + c_CW'(1);
                    end
                end
                c_DONE: begin
                    r_state <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_serial_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_serial_seq
// Brief    : Scoreboard bench for alu_serial_seq with an arithmetic reference.
// Revision : 1.0
// ============================================================================
module tb_alu_serial_seq;

    localparam int W = 32;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          start;
    logic [W-1:0]  src1;
    logic [W-1:0]  src2;
    logic          A_invert;
    logic          B_invert;
    logic [1:0]    operation;
    logic [2:0]    comp_sel;
    logic          busy;
    logic          done;
    logic [W-1:0]  result;
    logic          zero;
    logic          cout;
    logic          overflow;

    alu_serial_seq #(.WIDTH(W)) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .start     (start),
        .src1      (src1),
        .src2      (src2),
        .A_invert  (A_invert),
        .B_invert  (B_invert),
        .operation (operation),
        .comp_sel  (comp_sel),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .zero      (zero),
        .cout      (cout),
        .overflow  (overflow)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [W-1:0] res;
        logic         z;
        logic         c;
        logic         o;
        int           acc_cyc;
        int           done_cyc;
    } exp_t;

    exp_t q[$];
    int   cyc       = 0;
    logic rst_seen  = 1'b0;
    int   checks    = 0;
    int   failures  = 0;
    int   next_free = 0;

    localparam longint c_SMAX = 64'sd2147483647;
    localparam longint c_SMIN = -64'sd2147483648;

    always @(posedge clk_i) begin
        cyc      <= cyc + 1;
        rst_seen <= rst_i;
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, got, exp);
        end
    endtask

    // Reference: whole-word two's-complement arithmetic, no bit-level iteration.
    function automatic exp_t model(input logic [W-1:0] s1, input logic [W-1:0] s2,
                                   input logic ai, input logic bi,
                                   input logic [1:0] op, input logic [2:0] cs);
        exp_t         e;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W:0]   u;
        longint       sv;
        logic         ovf;
        logic         less;
        logic         eq;
        logic         cmp;
        a    = ai ? ~s1 : s1;
        b    = bi ? ~s2 : s2;
        u    = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, bi};
        sv   = longint'($signed(a)) + longint'($signed(b)) + longint'(bi);
        ovf  = (sv > c_SMAX) || (sv < c_SMIN);
        less = (sv < 0);
        eq   = (u[W-1:0] == '0);
        case (cs)
            3'b000:  cmp = less;
            3'b001:  cmp = !less && !eq;
            3'b010:  cmp = less || eq;
            3'b011:  cmp = !less;
            3'b110:  cmp = eq;
            3'b100:  cmp = !eq;
            default: cmp = 1'b0;
        endcase
        case (op)
            2'b00:   e.res = a & b;
            2'b01:   e.res = a | b;
            2'b10:   e.res = u[W-1:0];
            default: e.res = {{(W-1){1'b0}}, cmp};
        endcase
        e.z        = (e.res == '0);
        e.c        = u[W];
        e.o        = op[1] ? ovf : 1'b0;
        e.acc_cyc  = 0;
        e.done_cyc = 0;
        return e;
    endfunction

    task automatic push_exp();
        exp_t e;
        e          = model(src1, src2, A_invert, B_invert, operation, comp_sel);
        e.acc_cyc  = cyc + 1;
        e.done_cyc = cyc + 1 + W;
        q.push_back(e);
        next_free  = cyc + 1 + W + 2;
    endtask

    task automatic drive(input logic [W-1:0] s1, input logic [W-1:0] s2, input logic ai,
                         input logic bi, input logic [1:0] op, input logic [2:0] cs);
        src1      = s1;
        src2      = s2;
        A_invert  = ai;
        B_invert  = bi;
        operation = op;
        comp_sel  = cs;
    endtask

    task automatic wait_idle();
        while (cyc + 1 < next_free) @(negedge clk_i);
    endtask

    task automatic issue(input logic [W-1:0] s1, input logic [W-1:0] s2, input logic ai,
                         input logic bi, input logic [1:0] op, input logic [2:0] cs);
        @(negedge clk_i);
        wait_idle();
        drive(s1, s2, ai, bi, op, cs);
        start = 1'b1;
        push_exp();
        @(negedge clk_i);
        start = 1'b0;
    endtask

    // start stays high through RUN/DONE with new operands; only the IDLE-cycle
    // sample may be accepted.
    task automatic handshake();
        @(negedge clk_i);
        wait_idle();
        drive(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 2'b10, 3'b000);
        start = 1'b1;
        push_exp();
        forever begin
            @(negedge clk_i);
            drive(32'hDEAD_BEEF, 32'h0000_0001, 1'b0, 1'b1, 2'b11, 3'b000);
            if (cyc + 1 >= next_free) begin
                push_exp();
                break;
            end
        end
        @(negedge clk_i);
        start = 1'b0;
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // Monitor / scoreboard
    initial begin
        exp_t         e;
        logic         eb;
        logic         ed;
        logic [W-1:0] h_res;
        logic         h_z;
        logic         h_c;
        logic         h_o;
        h_res = '0;
        h_z   = 1'b0;
        h_c   = 1'b0;
        h_o   = 1'b0;
        forever begin
            @(negedge clk_i);
            if (rst_seen) begin
                q.delete();
                h_res = '0;
                h_z   = 1'b0;
                h_c   = 1'b0;
                h_o   = 1'b0;
            end
            eb = (q.size() > 0) && (cyc >= q[0].acc_cyc);
            ed = (q.size() > 0) && (cyc == q[0].done_cyc);
            check("busy", 64'(busy), 64'(eb));
            check("done", 64'(done), 64'(ed));
            if (ed) begin
                e = q.pop_front();
                check("result",   64'(result),   64'(e.res));
                check("zero",     64'(zero),     64'(e.z));
                check("cout",     64'(cout),     64'(e.c));
                check("overflow", 64'(overflow), 64'(e.o));
                h_res = e.res;
                h_z   = e.z;
                h_c   = e.c;
                h_o   = e.o;
            end else begin
                check("held_outputs", 64'({result, zero, cout, overflow}),
                      64'({h_res, h_z, h_c, h_o}));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog cyc=%0d got=timeout expected=finish", cyc);
        $fatal(1, "watchdog");
    end

    // Stimulus
    initial begin
        rst_i = 1'b1;
        start = 1'b0;
        drive('0, '0, 1'b0, 1'b0, 2'b00, 3'b000);
        repeat (3) @(negedge clk_i);
        rst_i     = 1'b0;
        next_free = cyc + 1;

        issue(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 2'b10, 3'b000);
        issue(32'h0000_0005, 32'h0000_0005, 1'b0, 1'b1, 2'b10, 3'b000);
        issue(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 2'b10, 3'b000);
        issue(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b1, 2'b11, 3'b000);
        issue(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b1, 2'b11, 3'b011);
        issue(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b1, 2'b11, 3'b100);
        issue(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 2'b11, 3'b000);
        issue(32'h0000_0007, 32'h0000_0007, 1'b0, 1'b1, 2'b11, 3'b110);
        issue(32'h0000_0007, 32'h0000_0007, 1'b0, 1'b1, 2'b11, 3'b010);
        issue(32'h0000_0007, 32'h0000_0007, 1'b0, 1'b1, 2'b11, 3'b001);
        issue(32'h0000_0007, 32'h0000_0007, 1'b0, 1'b1, 2'b11, 3'b111);
        issue(32'hF0F0_0000, 32'h0F0F_0000, 1'b1, 1'b1, 2'b00, 3'b000);
        issue(32'hF0F0_0000, 32'h0F0F_0000, 1'b0, 1'b0, 2'b01, 3'b000);

        handshake();

        // Abort in the middle of RUN, then restart one cycle after release.
        issue(32'h0000_1234, 32'h0000_4321, 1'b0, 1'b0, 2'b10, 3'b000);
        repeat (10) @(negedge clk_i);
        rst_i     = 1'b1;
        next_free = cyc + 2;
        @(negedge clk_i);
        rst_i = 1'b0;
        issue(32'h0000_00FF, 32'h0000_0F00, 1'b0, 1'b0, 2'b01, 3'b000);

        // Reset and start together must leave the block idle.
        @(negedge clk_i);
        wait_idle();
        drive(32'h5555_5555, 32'h1, 1'b0, 1'b0, 2'b10, 3'b000);
        rst_i     = 1'b1;
        start     = 1'b1;
        next_free = cyc + 2;
        @(negedge clk_i);
        rst_i = 1'b0;
        start = 1'b0;

        for (int i = 0; i < 40; i++) begin
            logic [1:0] op;
            op = 2'($urandom_range(0, 3));
            issue(pick(), pick(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  op, 3'($urandom_range(0, 7)));
            repeat ($urandom_range(0, 2)) @(negedge clk_i);
        end

        @(negedge clk_i);
        wait_idle();
        repeat (5) @(negedge clk_i);
        check("queue_empty", 64'(q.size()), 64'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
